// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite channel bundle between the command master and its slave.
interface axi4_lite_cmd_master_if #(
    parameter int unsigned AXI_DATA_WIDTH_P = 32,
    parameter int unsigned AXI_ADDR_WIDTH_P = 32
);
    logic [AXI_ADDR_WIDTH_P-1:0]   awaddr;
    logic                          awvalid;
    logic                          awready;
    logic [AXI_DATA_WIDTH_P-1:0]   wdata;
    logic [AXI_DATA_WIDTH_P/8-1:0] wstrb;
    logic                          wvalid;
    logic                          wready;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    logic [AXI_ADDR_WIDTH_P-1:0]   araddr;
    logic                          arvalid;
    logic                          arready;
    logic [AXI_DATA_WIDTH_P-1:0]   rdata;
    logic [1:0]                    rresp;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple cmd/rsp handshake.
module axi4_lite_cmd_master #(
    parameter int unsigned AXI_DATA_WIDTH_P = 32,
    parameter int unsigned AXI_ADDR_WIDTH_P = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    axi4_lite_cmd_master_if.master        axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_e;

    state_e                        state_q, state_d;
    logic [AXI_ADDR_WIDTH_P-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH_P-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH_P/8-1:0] wstrb_q, wstrb_d;
    logic                          aw_pend_q, aw_pend_d;
    logic                          w_pend_q, w_pend_d;
    logic [AXI_DATA_WIDTH_P-1:0]   rdata_q, rdata_d;
    logic [1:0]                    resp_q, resp_d;

    // State and transaction registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Next state: AW and W retire independently; WR_REQ exits once both are done.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                aw_pend_d = aw_pend_q && !axi.awready;
                w_pend_d  = w_pend_q && !axi.wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    resp_d  = axi.bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (axi.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    resp_d  = axi.rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered command.
    always_comb begin
        cmd_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        rsp_valid   = (state_q == RSP);
        rsp_rdata   = rdata_q;
        rsp_resp    = resp_q;
        axi.awaddr  = addr_q;
        axi.awvalid = aw_pend_q;
        axi.wdata   = wdata_q;
        axi.wstrb   = wstrb_q;
        axi.wvalid  = w_pend_q;
        axi.bready  = (state_q == WR_RESP);
        axi.araddr  = addr_q;
        axi.arvalid = (state_q == RD_REQ);
        axi.rready  = (state_q == RD_DATA);
    end

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Randomized bench: bus-level slave with programmable stalls plus a
// transaction-level memory/latency model for expected responses.
module tb_axi4_lite_cmd_master;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int proto_err = 0;

    int unsigned cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] smem [16];
    logic [31:0] mmem [16];

    axi4_lite_cmd_master_if #(.AXI_DATA_WIDTH_P(DW), .AXI_ADDR_WIDTH_P(AW)) axi ();

    axi4_lite_cmd_master #(.AXI_DATA_WIDTH_P(DW), .AXI_ADDR_WIDTH_P(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .busy(busy), .axi(axi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus-level slave; all activity on the falling edge, handshakes land on the rising edge.
    initial begin
        bit aw_act, w_act, ar_act, got_aw, got_w, got_ar, b_pend, r_pend;
        bit p_aw, p_w, p_b, p_ar, p_r, t_aw, t_w, t_ar;
        int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [31:0] la, lwd, lra;
        logic [3:0]  lws;
        {aw_act, w_act, ar_act, got_aw, got_w, got_ar, b_pend, r_pend} = '0;
        {p_aw, p_w, p_b, p_ar, p_r, t_aw, t_w, t_ar} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        la = '0; lwd = '0; lra = '0; lws = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {aw_act, w_act, ar_act, got_aw, got_w, got_ar, b_pend, r_pend} = '0;
                {p_aw, p_w, p_b, p_ar, p_r, t_aw, t_w, t_ar} = '0;
                axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
                axi.arready = 1'b0; axi.rvalid = 1'b0;
                continue;
            end
            if (p_aw) begin if (axi.awvalid) proto_err++; axi.awready = 1'b0; got_aw = 1; aw_act = 0; t_aw = 1; end
            if (p_w)  begin if (axi.wvalid)  proto_err++; axi.wready  = 1'b0; got_w  = 1; w_act  = 0; t_w  = 1; end
            if (p_ar) begin if (axi.arvalid) proto_err++; axi.arready = 1'b0; got_ar = 1; ar_act = 0; t_ar = 1; end
            if (p_b)  begin if (axi.bready)  proto_err++; axi.bvalid  = 1'b0; t_aw = 0; t_w = 0; end
            if (p_r)  begin if (axi.rready)  proto_err++; axi.rvalid  = 1'b0; t_ar = 0; end
            if (aw_act && !axi.awvalid) proto_err++;
            if (w_act && !axi.wvalid) proto_err++;
            if (ar_act && !axi.arvalid) proto_err++;
            if (axi.awvalid && axi.awaddr !== exp_addr) proto_err++;
            if (axi.wvalid && (axi.wdata !== exp_wdata || axi.wstrb !== exp_wstrb)) proto_err++;
            if (axi.arvalid && axi.araddr !== exp_addr) proto_err++;
            if (axi.bready && !(t_aw && t_w)) proto_err++;
            if (axi.rready && !t_ar) proto_err++;
            if (b_pend) begin
                if (b_cnt == 0) begin axi.bvalid = 1'b1; axi.bresp = cfg_bresp; b_pend = 0; end
                else b_cnt--;
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    axi.rvalid = 1'b1; axi.rdata = smem[lra[5:2]]; axi.rresp = cfg_rresp; r_pend = 0;
                end else r_cnt--;
            end
            if (got_aw && got_w) begin
                for (int b = 0; b < 4; b++) if (lws[b]) smem[la[5:2]][8*b +: 8] = lwd[8*b +: 8];
                got_aw = 0; got_w = 0; b_pend = 1; b_cnt = cfg_b;
            end
            if (got_ar) begin got_ar = 0; r_pend = 1; r_cnt = cfg_r; end
            if (axi.awvalid && !axi.awready) begin
                if (!aw_act) begin aw_act = 1; aw_cnt = cfg_aw; end
                if (aw_cnt == 0) axi.awready = 1'b1; else aw_cnt--;
            end
            if (axi.wvalid && !axi.wready) begin
                if (!w_act) begin w_act = 1; w_cnt = cfg_w; end
                if (w_cnt == 0) axi.wready = 1'b1; else w_cnt--;
            end
            if (axi.arvalid && !axi.arready) begin
                if (!ar_act) begin ar_act = 1; ar_cnt = cfg_ar; end
                if (ar_cnt == 0) axi.arready = 1'b1; else ar_cnt--;
            end
            p_aw = axi.awvalid && axi.awready;
            p_w  = axi.wvalid && axi.wready;
            p_ar = axi.arvalid && axi.arready;
            p_b  = axi.bvalid && axi.bready;
            p_r  = axi.rvalid && axi.rready;
            if (p_aw) la = axi.awaddr;
            if (p_w) begin lwd = axi.wdata; lws = axi.wstrb; end
            if (p_ar) lra = axi.araddr;
        end
    end

    // One command from issue to response handshake; entered and left just after a falling edge.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int unsigned daw, input int unsigned dw,
                          input int unsigned db, input int unsigned dar, input int unsigned dr,
                          input logic [1:0] resp, input int unsigned hold,
                          input bit park, input logic [31:0] naddr);
        logic [31:0] exp_rdata;
        int unsigned exp_lat, lat, k;
        cfg_aw = daw; cfg_w = dw; cfg_b = db; cfg_ar = dar; cfg_r = dr;
        cfg_bresp = resp; cfg_rresp = resp;
        exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        check("cmd_ready_idle", cmd_ready, 1);
        if (wr) begin
            exp_rdata = '0;
            for (int b = 0; b < 4; b++) if (strb[b]) mmem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
            exp_lat = 4 + ((daw > dw) ? daw : dw) + db;
        end else begin
            exp_rdata = mmem[addr[5:2]];
            exp_lat = 4 + dar + dr;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_write = 1'($urandom);
        lat = 1;
        check("busy", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
        while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, resp);
        if (park) begin cmd_write = 1'b0; cmd_addr = naddr; cmd_valid = 1'b1; end
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, resp, exp_rdata});
            check("cmd_ready_hold", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    // Abandon a write mid-flight and confirm nothing leaks out after release.
    task automatic reset_mid_write();
        bit seen;
        cfg_aw = 6; cfg_w = 6; cfg_b = 0;
        exp_addr = 32'h20; exp_wdata = 32'h5555AAAA; exp_wstrb = 4'hF;
        cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_awvalid", {axi.awvalid, axi.wvalid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid, busy}, 0);
        check("rst_addr", {axi.awaddr, axi.araddr}, 0);
        check("rst_data", {axi.wdata, axi.wstrb, rsp_resp}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid || busy) seen = 1; end
        check("no_rsp_after_rst", seen, 0);
        check("cmd_ready_after_rst", cmd_ready, 1);
    endtask

    initial begin
        bit wr;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            smem[i] = a;
            mmem[i] = a;
        end
        {cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r} = '0;
        cfg_bresp = '0; cfg_rresp = '0;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_ctrl", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid, busy}, 0);
        check("reset_rsp", {rsp_rdata, rsp_resp}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        do_txn(1, 32'h8, 32'h00001000, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
        do_txn(1, 32'h10, 32'hCAFE0001, 4'hF, 0, 3, 0, 0, 0, 2'b00, 0, 0, '0);
        do_txn(1, 32'h40, 32'hBAADFACE, 4'hF, 1, 0, 1, 0, 0, 2'b00, 0, 0, '0);
        do_txn(0, 32'h40, '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
        check("read_0x40", rsp_rdata, 32'hBAADFACE);
        do_txn(0, 32'h8, '0, 4'h0, 0, 0, 0, 2, 1, 2'b10, 1, 0, '0);
        do_txn(1, 32'h14, 32'h01020304, 4'h3, 2, 1, 0, 0, 0, 2'b11, 0, 0, '0);
        do_txn(1, 32'h44, 32'h11223344, 4'b0101, 0, 0, 0, 0, 0, 2'b00, 5, 1, 32'h44);
        do_txn(0, 32'h44, '0, 4'h0, 0, 0, 0, 0, 0, 2'b01, 0, 0, '0);
        reset_mid_write();
        do_txn(1, 32'h20, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);
        do_txn(0, 32'h20, '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, '0);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom);
            a = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
            do_txn(wr, a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom), $urandom_range(0, 2), 0, '0);
        end

        check("protocol", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
